// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit holding the architectural HI/LO pair.
// Latency: MULT_CYCLES / DIV_CYCLES after the issue cycle; HI/LO readable the cycle after.
// Backpressure: busy is raised in the issue cycle and held through EXEC; requests seen while busy are dropped.
module mult_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [4:0]  ctrl,
  output logic [31:0] S,
  output logic        busy,
  output logic [3:0]  count_down
);

  localparam logic [4:0] OP_MULT  = 5'd1;
  localparam logic [4:0] OP_MULTU = 5'd2;
  localparam logic [4:0] OP_DIV   = 5'd3;
  localparam logic [4:0] OP_DIVU  = 5'd4;
  localparam logic [4:0] OP_MTHI  = 5'd5;
  localparam logic [4:0] OP_MTLO  = 5'd6;
  localparam logic [4:0] OP_MFHI  = 5'd7;
  localparam logic [4:0] OP_MFLO  = 5'd8;

  typedef enum logic {IDLE, EXEC} state_t;

  state_t      state;
  logic [4:0]  op;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] hi_n;
  logic [31:0] lo_n;
  logic        start;
  logic        div_zero;

  // Datapath intermediates
  logic signed [63:0] prod_s;
  logic [63:0]        prod_u;
  logic               div_signed;
  logic [31:0]        a_mag;
  logic [31:0]        b_mag;
  logic [31:0]        b_safe;
  logic [31:0]        q_mag;
  logic [31:0]        r_mag;
  logic               q_neg;
  logic               r_neg;

  // A start is only accepted from IDLE; codes 9..31 fall outside this range and act as none
  assign start    = (state == IDLE) && (ctrl >= OP_MULT) && (ctrl <= OP_DIVU);
  assign busy     = (state == EXEC) || start;
  assign div_zero = (b_q == 32'd0);

  // Read port: combinational view of the committed HI/LO (old value while EXEC is in flight)
  always_comb begin
    S = 32'd0;
    if (ctrl == OP_MFHI) S = hi;
    else if (ctrl == OP_MFLO) S = lo;
  end

  // Pending result computed from the latched operands; committed only when EXEC finishes
  always_comb begin
    prod_s     = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
    prod_u     = {32'd0, a_q} * {32'd0, b_q};
    div_signed = (op == OP_DIV);
    // Signed divide works on magnitudes; 0x80000000 negates to itself, which is the
    // correct unsigned magnitude, so the overflow corner falls out naturally.
    a_mag      = (div_signed && a_q[31]) ? (~a_q + 32'd1) : a_q;
    b_mag      = (div_signed && b_q[31]) ? (~b_q + 32'd1) : b_q;
    b_safe     = (b_mag == 32'd0) ? 32'd1 : b_mag;
    q_mag      = a_mag / b_safe;
    r_mag      = a_mag % b_safe;
    q_neg      = div_signed && (a_q[31] ^ b_q[31]);
    r_neg      = div_signed && a_q[31];
    hi_n       = hi;
    lo_n       = lo;
    case (op)
      OP_MULT: begin
        hi_n = $unsigned(prod_s[63:32]);
        lo_n = $unsigned(prod_s[31:0]);
      end
      OP_MULTU: begin
        hi_n = prod_u[63:32];
        lo_n = prod_u[31:0];
      end
      OP_DIV, OP_DIVU: begin
        lo_n = q_neg ? (~q_mag + 32'd1) : q_mag;
        hi_n = r_neg ? (~r_mag + 32'd1) : r_mag;
      end
      default: begin
        hi_n = hi;
        lo_n = lo;
      end
    endcase
  end

  // Control FSM: issue, countdown, commit; also services mthi/mtlo while idle
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      op         <= 5'd0;
      a_q        <= 32'd0;
      b_q        <= 32'd0;
      hi         <= 32'd0;
      lo         <= 32'd0;
      count_down <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            op         <= ctrl;
            a_q        <= A;
            b_q        <= B;
            count_down <= (ctrl == OP_MULT || ctrl == OP_MULTU) ? 4'(MULT_CYCLES)
                                                                 : 4'(DIV_CYCLES);
            state      <= EXEC;
          end else if (ctrl == OP_MTHI) begin
            hi <= A;
          end else if (ctrl == OP_MTLO) begin
            lo <= A;
          end
        end
        EXEC: begin
          if (count_down == 4'd1) begin
            state      <= IDLE;
            count_down <= 4'd0;
            // Divide by zero keeps HI/LO intact but still consumes the full busy period
            if (!((op == OP_DIV || op == OP_DIVU) && div_zero)) begin
              hi <= hi_n;
              lo <= lo_n;
            end
          end else begin
            count_down <= count_down - 4'd1;
          end
        end
        default: begin
          state      <= IDLE;
          count_down <= 4'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit with a queue-based scoreboard.
// Stimulus pushes per-cycle status expectations and mfhi/mflo read expectations;
// a monitor on the falling edge pops and compares them.
module tb_mult_div_unit;

  logic        clk;
  logic        reset;
  logic [31:0] A;
  logic [31:0] B;
  logic [4:0]  ctrl;
  logic [31:0] S;
  logic        busy;
  logic [3:0]  count_down;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    bit         care;
    bit         eb;
    logic [3:0] ecd;
    string      nm;
  } stat_t;

  typedef struct {
    logic [31:0] v;
    string       nm;
  } rd_t;

  stat_t sq[$];
  rd_t   rq[$];

  mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk        (clk),
    .reset      (reset),
    .A          (A),
    .B          (B),
    .ctrl       (ctrl),
    .S          (S),
    .busy       (busy),
    .count_down (count_down)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs; record what the monitor should see at this cycle's falling edge
  task automatic step(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b,
                      input bit care, input bit eb, input int ecd, input string nm,
                      input logic [31:0] es = 32'd0);
    stat_t s;
    rd_t   r;
    ctrl = c;
    A    = a;
    B    = b;
    s.care = care;
    s.eb   = eb;
    s.ecd  = 4'(ecd);
    s.nm   = nm;
    sq.push_back(s);
    if (c == 5'd7 || c == 5'd8) begin
      r.v  = es;
      r.nm = nm;
      rq.push_back(r);
    end
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  // Issue a start and check busy/count_down through the whole EXEC window
  task automatic run_op(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b,
                        input int cycles, input string nm);
    step(c, a, b, 1, 1'b1, 0, {nm, "_issue"});
    for (int k = cycles; k >= 1; k--)
      step(5'd0, 32'd0, 32'd0, 1, 1'b1, k, {nm, "_cd"});
  endtask

  // Monitor: compares status each cycle and S whenever a read is presented
  initial begin
    stat_t s;
    rd_t   r;
    forever begin
      @(negedge clk);
      if (sq.size() > 0) begin
        s = sq.pop_front();
        if (s.care) begin
          n_cmp++;
          if (busy !== s.eb || count_down !== s.ecd) begin
            n_bad++;
            $display("FAIL %s: busy=%b count_down=%0d, expected busy=%b count_down=%0d",
                     s.nm, busy, count_down, s.eb, s.ecd);
          end
        end
        if (ctrl == 5'd7 || ctrl == 5'd8) begin
          n_cmp++;
          if (rq.size() == 0) begin
            n_bad++;
            $display("FAIL %s: read with no expectation queued, S=%h", s.nm, S);
          end else begin
            r = rq.pop_front();
            if (S !== r.v) begin
              n_bad++;
              $display("FAIL %s: S=%h expected %h", r.nm, S, r.v);
            end
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    ctrl  = 5'd0;
    A     = 32'd0;
    B     = 32'd0;
    // Reset: first cycle state unknown, second cycle fully cleared
    step(5'd0, 32'd0, 32'd0, 0, 1'b0, 0, "rst0");
    step(5'd7, 32'd0, 32'd0, 1, 1'b0, 0, "rst_hi", 32'd0);
    reset = 1'b0;
    step(5'd8, 32'd0, 32'd0, 1, 1'b0, 0, "rst_lo", 32'd0);
    step(5'd0, 32'd0, 32'd0, 1, 1'b0, 0, "idle");
    step(5'd12, 32'd5, 32'd5, 1, 1'b0, 0, "ctrl12_none");

    // Signed multiply -2 * 3
    run_op(5'd1, 32'hFFFFFFFE, 32'd3, 5, "mult_neg");
    step(5'd7, 32'd0, 32'd0, 1, 1'b0, 0, "mult_neg_hi", 32'hFFFFFFFF);
    step(5'd8, 32'd0, 32'd0, 1, 1'b0, 0, "mult_neg_lo", 32'hFFFFFFFA);

    // Unsigned multiply max * max
    run_op(5'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 5, "multu_max");
    step(5'd7, 32'd0, 32'd0, 1, 1'b0, 0, "multu_hi", 32'hFFFFFFFE);
    step(5'd8, 32'd0, 32'd0, 1, 1'b0, 0, "multu_lo", 32'h00000001);

    // Unsigned divide 7 / 2
    run_op(5'd4, 32'd7, 32'd2, 10, "divu_7_2");
    step(5'd8, 32'd0, 32'd0, 1, 1'b0, 0, "divu_lo", 32'd3);
    step(5'd7, 32'd0, 32'd0, 1, 1'b0, 0, "divu_hi", 32'd1);

    // Signed divide -7 / 2
    run_op(5'd3, 32'hFFFFFFF9, 32'd2, 10, "div_neg");
    step(5'd8, 32'd0, 32'd0, 1, 1'b0, 0, "div_neg_lo", 32'hFFFFFFFD);
    step(5'd7, 32'd0, 32'd0, 1, 1'b0, 0, "div_neg_hi", 32'hFFFFFFFF);

    // Signed overflow corner
    run_op(5'd3, 32'h80000000, 32'hFFFFFFFF, 10, "div_ovf");
    step(5'd8, 32'd0, 32'd0, 1, 1'b0, 0, "div_ovf_lo", 32'h80000000);
    step(5'd7, 32'd0, 32'd0, 1, 1'b0, 0, "div_ovf_hi", 32'd0);

    // mthi/mtlo then divide by zero leaves them intact
    step(5'd5, 32'h11, 32'd0, 1, 1'b0, 0, "mthi");
    step(5'd6, 32'h22, 32'd0, 1, 1'b0, 0, "mtlo");
    step(5'd7, 32'd0, 32'd0, 1, 1'b0, 0, "mthi_rd", 32'h11);
    run_op(5'd3, 32'd5, 32'd0, 10, "div_zero");
    step(5'd7, 32'd0, 32'd0, 1, 1'b0, 0, "div_zero_hi", 32'h11);
    step(5'd8, 32'd0, 32'd0, 1, 1'b0, 0, "div_zero_lo", 32'h22);

    // Requests during EXEC are ignored; reads return pre-op values
    step(5'd1, 32'd2, 32'd3, 1, 1'b1, 0, "ign_issue");
    step(5'd6, 32'h55, 32'd0, 1, 1'b1, 5, "ign_mtlo");
    step(5'd1, 32'd9, 32'd9, 1, 1'b1, 4, "ign_mult");
    step(5'd8, 32'd0, 32'd0, 1, 1'b1, 3, "ign_mflo_old", 32'h22);
    step(5'd7, 32'd0, 32'd0, 1, 1'b1, 2, "ign_mfhi_old", 32'h11);
    step(5'd0, 32'd0, 32'd0, 1, 1'b1, 1, "ign_last");
    step(5'd8, 32'd0, 32'd0, 1, 1'b0, 0, "ign_lo", 32'd6);
    step(5'd7, 32'd0, 32'd0, 1, 1'b0, 0, "ign_hi", 32'd0);

    // Reset in the middle of mult 5*5 aborts with no commit
    step(5'd5, 32'h77, 32'd0, 1, 1'b0, 0, "pre_rst_mthi");
    step(5'd1, 32'd5, 32'd5, 1, 1'b1, 0, "rst_issue");
    step(5'd0, 32'd0, 32'd0, 1, 1'b1, 5, "rst_t1");
    step(5'd0, 32'd0, 32'd0, 1, 1'b1, 4, "rst_t2");
    reset = 1'b1;
    step(5'd0, 32'd0, 32'd0, 1, 1'b1, 3, "rst_t3");
    reset = 1'b0;
    step(5'd0, 32'd0, 32'd0, 1, 1'b0, 0, "rst_after");
    step(5'd7, 32'd0, 32'd0, 1, 1'b0, 0, "rst_hi_clr", 32'd0);
    step(5'd8, 32'd0, 32'd0, 1, 1'b0, 0, "rst_lo_clr", 32'd0);
    for (int k = 0; k < 4; k++)
      step(5'd0, 32'd0, 32'd0, 1, 1'b0, 0, "rst_quiet");
    step(5'd8, 32'd0, 32'd0, 1, 1'b0, 0, "rst_no_commit", 32'd0);

    // Back-to-back: mult 2*2 then divu 9/4 in its T+6
    run_op(5'd1, 32'd2, 32'd2, 5, "b2b_mult");
    step(5'd4, 32'd9, 32'd4, 1, 1'b1, 0, "b2b_divu_issue");
    step(5'd8, 32'd0, 32'd0, 1, 1'b1, 10, "b2b_mult_lo", 32'd4);
    for (int k = 9; k >= 1; k--)
      step(5'd0, 32'd0, 32'd0, 1, 1'b1, k, "b2b_divu_cd");
    step(5'd8, 32'd0, 32'd0, 1, 1'b0, 0, "b2b_lo", 32'd2);
    step(5'd7, 32'd0, 32'd0, 1, 1'b0, 0, "b2b_hi", 32'd1);

    // Every queued read must have been consumed
    n_cmp++;
    if (rq.size() != 0) begin
      n_bad++;
      $display("FAIL read_queue_drain: %0d left, expected 0", rq.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
